reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/qu_common.sv | 35 +++
 rtl/priority_picker.sv | 22 ++
 rtl/reservation_station.sv | 141 ++++++++++++++
 tb/tb_reservation_station.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qu_common.sv
// Shared queue-unit types: reservation-station slot address, entry layout and
// default sizing, plus the CDB tag-match helper used for wakeup and bypass.
package qu_common;

  localparam int RES_ST_DEPTH_DEFAULT = 8;
  localparam int DATA_WIDTH_DEFAULT   = 32;
  localparam int PHY_RF_ADDR_WIDTH    = 6;
  localparam int UOP_WIDTH            = 8;
  localparam int RES_ST_ADDR_WIDTH    = $clog2(RES_ST_DEPTH_DEFAULT);

  typedef logic [RES_ST_ADDR_WIDTH-1:0]  res_st_addr_t;
  typedef logic [PHY_RF_ADDR_WIDTH-1:0]  phy_tag_t;
  typedef logic [DATA_WIDTH_DEFAULT-1:0] data_t;

  typedef struct packed {
    logic                 valid;
    logic [UOP_WIDTH-1:0] uop;
    phy_tag_t             rs1_tag;
    data_t                rs1_val;
    logic                 rs1_rdy;
    phy_tag_t             rs2_tag;
    data_t                rs2_val;
    logic                 rs2_rdy;
    phy_tag_t             rd_tag;
  } res_st_cell_t;

  // An operand wakes only while it is still waiting on the broadcast tag.
  function automatic logic tag_hit(input logic     cdb_v,
                                   input phy_tag_t cdb_t,
                                   input phy_tag_t op_tag,
                                   input logic     op_rdy);
    return cdb_v && !op_rdy && (cdb_t == op_tag);
  endfunction

endpackage

// File: rtl/priority_picker.sv
// Lowest-index one-hot picker: returns the index of the lowest set request bit
// and whether any bit is set. Index is 0 when no request is present.
module priority_picker #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/reservation_station.sv
// Reservation station: slot allocation, CDB wakeup with write bypass, and a
// one-deep issue register. Optional perf counters under QU_RES_ST_PERF_EN.
module reservation_station
  import qu_common::*;
#(
  parameter int RES_ST_DEPTH = RES_ST_DEPTH_DEFAULT,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  res_st_addr_t                 wr_addr,
  input  res_st_cell_t                 wr_data,
  output res_st_addr_t                 free_addr,
  output logic                         full,
  output logic                         wr_err,
  input  logic                         cdb_valid,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] cdb_tag,
  input  logic [DATA_WIDTH-1:0]        cdb_data,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output res_st_cell_t                 issue_data
`ifdef QU_RES_ST_PERF_EN
  ,
  output logic [$clog2(RES_ST_DEPTH):0] occupancy,
  output logic [31:0]                   issue_count
`endif
);

  localparam int AW = $clog2(RES_ST_DEPTH);

  res_st_cell_t            w_cells [RES_ST_DEPTH];
  logic [RES_ST_DEPTH-1:0] w_valid;
  logic [RES_ST_DEPTH-1:0] w_ready;
  logic [RES_ST_DEPTH-1:0] w_wr_hit;
  logic [AW-1:0]           w_free_idx;
  logic [AW-1:0]           w_iss_idx;
  logic                    w_free_any;
  logic                    w_iss_any;
  logic                    w_load;
  logic                    w_take;
  data_t                   w_cdb_data;

  logic                    r_iss_vld;
  res_st_cell_t            r_iss_data;
  logic                    r_wr_err;

  assign w_cdb_data = data_t'(cdb_data);

  for (genvar g = 0; g < RES_ST_DEPTH; g++) begin : g_ent
    res_st_cell_t r_cell;
    res_st_cell_t w_nxt;

    assign w_cells[g]  = r_cell;
    assign w_valid[g]  = r_cell.valid;
    assign w_ready[g]  = r_cell.valid & r_cell.rs1_rdy & r_cell.rs2_rdy;
    assign w_wr_hit[g] = wr_en && (wr_addr == res_st_addr_t'(g)) && !r_cell.valid;

    // Wakeup is applied after the write mux so a fresh entry sees the same-cycle broadcast.
    always_comb begin
      w_nxt = w_wr_hit[g] ? wr_data : r_cell;
      if (w_wr_hit[g]) w_nxt.valid = 1'b1;
      if (w_nxt.valid && tag_hit(cdb_valid, cdb_tag, w_nxt.rs1_tag, w_nxt.rs1_rdy)) begin
        w_nxt.rs1_val = w_cdb_data;
        w_nxt.rs1_rdy = 1'b1;
      end
      if (w_nxt.valid && tag_hit(cdb_valid, cdb_tag, w_nxt.rs2_tag, w_nxt.rs2_rdy)) begin
        w_nxt.rs2_val = w_cdb_data;
        w_nxt.rs2_rdy = 1'b1;
      end
      if (w_take && (w_iss_idx == AW'(g))) w_nxt.valid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       r_cell       <= '0;
      else if (flush) r_cell.valid <= 1'b0;
      else            r_cell       <= w_nxt;
    end
  end

  priority_picker #(.N(RES_ST_DEPTH), .W(AW)) u_free_pick (
    .i_req (~w_valid),
    .o_idx (w_free_idx),
    .o_any (w_free_any)
  );

  priority_picker #(.N(RES_ST_DEPTH), .W(AW)) u_iss_pick (
    .i_req (w_ready),
    .o_idx (w_iss_idx),
    .o_any (w_iss_any)
  );

  assign full      = &w_valid;
  assign free_addr = w_free_any ? res_st_addr_t'(w_free_idx) : '0;

  // Issue register refills when empty or draining; the source slot is freed on the same edge.
  assign w_load = !r_iss_vld || issue_ready;
  assign w_take = w_load && w_iss_any && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iss_vld  <= 1'b0;
      r_iss_data <= '0;
    end else if (flush) begin
      r_iss_vld  <= 1'b0;
    end else if (w_load) begin
      r_iss_vld <= w_iss_any;
      if (w_iss_any) r_iss_data <= w_cells[w_iss_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wr_err <= 1'b0;
    else      r_wr_err <= wr_en && !flush && w_valid[wr_addr];
  end

  assign issue_valid = r_iss_vld;
  assign issue_data  = r_iss_data;
  assign wr_err      = r_wr_err;

`ifdef QU_RES_ST_PERF_EN
  localparam int OCC_W = $clog2(RES_ST_DEPTH) + 1;

  logic [31:0] r_issue_cnt;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < RES_ST_DEPTH; i++) occupancy = occupancy + OCC_W'(w_valid[i]);
  end

  // Counts handshakes across flushes; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            r_issue_cnt <= '0;
    else if (r_iss_vld && issue_ready)   r_issue_cnt <= r_issue_cnt + 32'd1;
  end

  assign issue_count = r_issue_cnt;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: expected issues are queued as
// stimulus is driven and retired against each observed issue handshake.
module tb_reservation_station;
  import qu_common::*;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         flush = 1'b0;
  logic                         wr_en = 1'b0;
  res_st_addr_t                 wr_addr = '0;
  res_st_cell_t                 wr_data = '0;
  logic                         cdb_valid = 1'b0;
  logic [PHY_RF_ADDR_WIDTH-1:0] cdb_tag = '0;
  logic [DATA_WIDTH_DEFAULT-1:0] cdb_data = '0;
  logic                         issue_ready = 1'b0;
  res_st_addr_t                 free_addr;
  logic                         full;
  logic                         wr_err;
  logic                         issue_valid;
  res_st_cell_t                 issue_data;
`ifdef QU_RES_ST_PERF_EN
  logic [$clog2(RES_ST_DEPTH_DEFAULT):0] occupancy;
  logic [31:0]                           issue_count;
`endif

  int n_vec = 0;
  int n_mis = 0;
  int n_hs  = 0;
  res_st_cell_t sb[$];

  reservation_station dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .free_addr   (free_addr),
    .full        (full),
    .wr_err      (wr_err),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_data  (issue_data)
`ifdef QU_RES_ST_PERF_EN
    ,
    .occupancy   (occupancy),
    .issue_count (issue_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input res_st_cell_t c);
    wr_en   = 1'b1;
    wr_addr = res_st_addr_t'(a);
    wr_data = c;
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic res_st_cell_t mk(input phy_tag_t t1, input data_t v1, input logic r1,
                                      input phy_tag_t t2, input data_t v2, input logic r2,
                                      input phy_tag_t rd);
    res_st_cell_t c;
    c         = '0;
    c.uop     = 8'h5A;
    c.rs1_tag = t1;
    c.rs1_val = v1;
    c.rs1_rdy = r1;
    c.rs2_tag = t2;
    c.rs2_val = v2;
    c.rs2_rdy = r2;
    c.rd_tag  = rd;
    return c;
  endfunction

  // Retire one expected entry per handshake, sampled mid-cycle.
  always @(negedge clk) begin
    res_st_cell_t ex;
    if (rst && issue_valid && issue_ready) begin
      n_hs++;
      if (sb.size() == 0) begin
        chk("sb_extra_issue", 64'(sb.size()), 64'd1);
      end else begin
        ex = sb.pop_front();
        chk("sb_rd_tag", 64'(issue_data.rd_tag), 64'(ex.rd_tag));
        chk("sb_rs1_val", 64'(issue_data.rs1_val), 64'(ex.rs1_val));
        chk("sb_rs2_val", 64'(issue_data.rs2_val), 64'(ex.rs2_val));
      end
    end
  end

  initial begin
    res_st_cell_t e, ex, e1, e4;

    // Async reset while the clock runs
    #2 rst = 1'b0;
    #10;
    chk("rst_iss_vld", 64'(issue_valid), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_free", 64'(free_addr), 0);
    chk("rst_wr_err", 64'(wr_err), 0);
    chk("rst_iss_data", 64'(|issue_data), 0);
    tick();
    rst = 1'b1;
    issue_ready = 1'b1;

    // Ready-at-write entry issues two edges later
    e = mk(1, 5, 1, 2, 7, 1, 1);
    sb.push_back(e);
    wr(0, e);
    chk("t1_lat1", 64'(issue_valid), 0);
    chk("t1_free", 64'(free_addr), 1);
    tick();
    chk("t1_iss", 64'(issue_valid), 1);
    chk("t1_rs1", 64'(issue_data.rs1_val), 5);
    chk("t1_rs2", 64'(issue_data.rs2_val), 7);
    chk("t1_freed", 64'(free_addr), 0);
    tick();
    chk("t1_drop", 64'(issue_valid), 0);

    // CDB wakeup of a stored operand
    e = mk(9, 0, 0, 3, 32'h33, 1, 2);
    wr(2, e);
    chk("t2_wait", 64'(issue_valid), 0);
    cdb_valid = 1'b1; cdb_tag = 9; cdb_data = 32'hABCD;
    e.rs1_val = 32'hABCD;
    sb.push_back(e);
    tick();
    cdb_valid = 1'b0;
    chk("t2_lat", 64'(issue_valid), 0);
    tick();
    chk("t2_iss", 64'(issue_valid), 1);
    chk("t2_rs1", 64'(issue_data.rs1_val), 32'hABCD);
    tick();

    // Write coinciding with a matching broadcast
    e = mk(7, 32'h22, 1, 4, 0, 0, 3);
    ex = e; ex.rs2_val = 32'h11;
    sb.push_back(ex);
    cdb_valid = 1'b1; cdb_tag = 4; cdb_data = 32'h11;
    wr(3, e);
    cdb_valid = 1'b0;
    chk("t3_lat", 64'(issue_valid), 0);
    tick();
    chk("t3_iss", 64'(issue_valid), 1);
    chk("t3_rs2", 64'(issue_data.rs2_val), 32'h11);
    tick();

    // Two entries woken together: lowest index first, back to back
    wr(6, mk(40, 0, 0, 1, 32'h61, 1, 46));
    wr(2, mk(40, 0, 0, 1, 32'h21, 1, 42));
    sb.push_back(mk(40, 32'h4040, 1, 1, 32'h21, 1, 42));
    sb.push_back(mk(40, 32'h4040, 1, 1, 32'h61, 1, 46));
    cdb_valid = 1'b1; cdb_tag = 40; cdb_data = 32'h4040;
    tick();
    cdb_valid = 1'b0;
    chk("t4_lat", 64'(issue_valid), 0);
    tick();
    chk("t4_first", 64'(issue_data.rd_tag), 42);
    tick();
    chk("t4_second_v", 64'(issue_valid), 1);
    chk("t4_second", 64'(issue_data.rd_tag), 46);
    tick();
    chk("t4_empty", 64'(issue_valid), 0);

    // Fill all slots, reject a write, drain one
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(i, mk(phy_tag_t'(20 + i), 0, 0, 1, data_t'(i), 1, phy_tag_t'(10 + i)));
      chk("t5_free", 64'(free_addr), (i == 7) ? 0 : i + 1);
    end
    chk("t5_full", 64'(full), 1);
    wr(5, mk(1, 32'hDEAD, 1, 1, 32'hBEEF, 1, 63));
    chk("t5_err", 64'(wr_err), 1);
    chk("t5_full2", 64'(full), 1);
    tick();
    chk("t5_err_pulse", 64'(wr_err), 0);
    chk("t5_noiss", 64'(issue_valid), 0);
    sb.push_back(mk(25, 32'h55, 1, 1, 5, 1, 15));
    cdb_valid = 1'b1; cdb_tag = 25; cdb_data = 32'h55;
    tick();
    cdb_valid = 1'b0;
    chk("t5_still_full", 64'(full), 1);
    tick();
    chk("t5_iss", 64'(issue_valid), 1);
    chk("t5_slot5", 64'(issue_data.rd_tag), 15);
    chk("t5_notfull", 64'(full), 0);
    chk("t5_free5", 64'(free_addr), 5);
    issue_ready = 1'b1;
    tick();
    chk("t5_drained", 64'(issue_valid), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_free", 64'(free_addr), 0);

    // Back-pressure holds the issue register stable
    issue_ready = 1'b0;
    e1 = mk(1, 32'h101, 1, 1, 32'h102, 1, 21);
    e4 = mk(1, 32'h401, 1, 1, 32'h402, 1, 24);
    sb.push_back(e1);
    sb.push_back(e4);
    wr(1, e1);
    wr(4, e4);
    for (int i = 0; i < 3; i++) begin
      chk("t6_hold_v", 64'(issue_valid), 1);
      chk("t6_hold_rd", 64'(issue_data.rd_tag), 21);
      chk("t6_hold_rs1", 64'(issue_data.rs1_val), 32'h101);
      tick();
    end
    issue_ready = 1'b1;
    tick();
    chk("t6_next_v", 64'(issue_valid), 1);
    chk("t6_next_rd", 64'(issue_data.rd_tag), 24);
    tick();
    chk("t6_empty", 64'(issue_valid), 0);

    // Flush with four valid entries and a held issue
    issue_ready = 1'b0;
    wr(0, mk(1, 1, 1, 1, 2, 1, 30));
    wr(1, mk(50, 0, 0, 1, 0, 1, 31));
    wr(0, mk(50, 0, 0, 1, 0, 1, 32));
    wr(2, mk(50, 0, 0, 1, 0, 1, 33));
    wr(3, mk(50, 0, 0, 1, 0, 1, 34));
    chk("t7_pre_v", 64'(issue_valid), 1);
    chk("t7_pre_free", 64'(free_addr), 4);
`ifdef QU_RES_ST_PERF_EN
    chk("t7_pre_occ", 64'(occupancy), 4);
`endif
    flush = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 50; cdb_data = 32'h5050;
    wr(0, mk(1, 1, 1, 1, 1, 1, 37));
    flush = 1'b0;
    cdb_valid = 1'b0;
    chk("t7_iss_v", 64'(issue_valid), 0);
    chk("t7_free", 64'(free_addr), 0);
    chk("t7_full", 64'(full), 0);
    chk("t7_wr_err", 64'(wr_err), 0);
`ifdef QU_RES_ST_PERF_EN
    chk("t7_occ", 64'(occupancy), 0);
    chk("t7_cnt", 64'(issue_count), 64'(n_hs));
`endif
    issue_ready = 1'b1;
    flush = 1'b1;
    wr(4, mk(1, 1, 1, 1, 1, 1, 38));
    flush = 1'b0;
    chk("t7_ovr_free", 64'(free_addr), 0);
    tick(2);
    chk("t7_ovr_iss", 64'(issue_valid), 0);

    // Reset mid-operation: no stale issue afterwards
    issue_ready = 1'b0;
    wr(2, mk(1, 3, 1, 1, 4, 1, 35));
    wr(5, mk(60, 0, 0, 1, 0, 1, 36));
    chk("t8_pre_v", 64'(issue_valid), 1);
    #2 rst = 1'b0;
    #1;
    n_hs = 0;
    chk("t8_iss_v", 64'(issue_valid), 0);
    chk("t8_iss_data", 64'(|issue_data), 0);
    chk("t8_free", 64'(free_addr), 0);
`ifdef QU_RES_ST_PERF_EN
    chk("t8_cnt", 64'(issue_count), 0);
    chk("t8_occ", 64'(occupancy), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    issue_ready = 1'b1;
    tick();
    chk("t8_no_stale", 64'(issue_valid), 0);
    e = mk(1, 32'h77, 1, 1, 32'h88, 1, 39);
    sb.push_back(e);
    wr(0, e);
    tick();
    chk("t8_restart", 64'(issue_valid), 1);
    tick();
`ifdef QU_RES_ST_PERF_EN
    chk("t8_cnt_after", 64'(issue_count), 64'(n_hs));
`endif
    chk("sb_drain", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
